// File: rtl/fault_campaign_pkg.sv
// Shared types and constants for the ECC fault-injection campaign sequencer.
package fault_campaign_pkg;

  localparam int CNT_W = 8;

  localparam logic [31:0]      NO_FLIP      = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] BASELINE_IDX = 8'hFE;
  localparam logic [CNT_W-1:0] CNT_MAX      = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  // Counter increment that sticks at the maximum value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/fault_wdog.sv
// Loadable down-counter used as the per-trial decoder-response watchdog.
// Clear has priority over load, load over decrement; the count stops at zero
// and o_expired is high whenever the count is zero.
module fault_wdog #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             r_expired;

  // Next count value from clear/load/enable requests.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Count register with a registered zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_expired <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_expired <= (w_cnt_nxt == '0);
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/fault_campaign_ctrl.sv
// ECC fault-injection campaign sequencer: one baseline trial (no flip) then
// one trial per codeword bit, each launched, timed out by a watchdog and
// scored into pass/fail/timeout counters.
// Optional build macro FAULT_LOG_EN adds first_fail_pos/first_fail_data,
// which record the index and decoded payload of the first failing trial.
module fault_campaign_ctrl
  import fault_campaign_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_BITS = 40,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] enc_din,
  output logic              enc_valid,
  output logic [31:0]       flip_sel,
  input  logic [DATA_W-1:0] dec_dout,
  input  logic              dec_corr,
  input  logic              dec_uncorr,
  input  logic              dec_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  tmo_cnt
`ifdef FAULT_LOG_EN
  ,
  output logic [CNT_W-1:0]  first_fail_pos,
  output logic [DATA_W-1:0] first_fail_data
`endif
);

  localparam int               TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    WD_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BITS);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_abort;
  logic               w_cap;
  logic               w_tmo_evt;
  logic               w_pass_evt;
  logic               w_fail_evt;
  logic               w_adv;
  logic               w_trial_pass;
  logic               w_wdog_exp;
  logic [CNT_W-1:0]   w_p_next;

  logic [DATA_W-1:0]  r_seed;
  logic [CNT_W-1:0]   r_idx;
  logic [31:0]        r_flip;
  logic               r_enc_valid;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_pass;
  logic [CNT_W-1:0]   r_fail;
  logic [CNT_W-1:0]   r_tmo;
  logic [DATA_W-1:0]  r_dout;
  logic               r_corr;
  logic               r_uncorr;

  // The watchdog is armed in LAUNCH so that WAIT lasts at most TIMEOUT cycles.
  fault_wdog #(.WIDTH(TW)) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_accept || w_abort),
    .i_load     (r_state == ST_LAUNCH),
    .i_load_val (WD_LOAD),
    .i_en       (r_state == ST_WAIT),
    .o_expired  (w_wdog_exp)
  );

  // Baseline expects a clean decode; a swept position expects a corrected one.
  assign w_trial_pass = (r_dout == r_seed) && !r_uncorr &&
                        ((r_idx == BASELINE_IDX) ? !r_corr : r_corr);

  assign w_p_next = (r_idx == BASELINE_IDX) ? {CNT_W{1'b0}}
                                            : (r_idx + {{(CNT_W-1){1'b0}}, 1'b1});

  // Next-state logic and one-cycle event strobes; abort outranks everything.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_cap       = 1'b0;
    w_tmo_evt   = 1'b0;
    w_pass_evt  = 1'b0;
    w_fail_evt  = 1'b0;
    w_adv       = 1'b0;
    if (abort && (r_state != ST_IDLE)) begin
      w_abort     = 1'b1;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LAUNCH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LAUNCH: w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (dec_valid) begin
            w_cap       = 1'b1;
            w_state_nxt = ST_CHECK;
          end else if (w_wdog_exp) begin
            w_tmo_evt   = 1'b1;
            w_state_nxt = ST_NEXT;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_CHECK: begin
          if (w_trial_pass) begin
            w_pass_evt = 1'b1;
          end else begin
            w_fail_evt = 1'b1;
          end
          w_state_nxt = ST_NEXT;
        end
        ST_NEXT: begin
          w_adv = 1'b1;
          if (w_p_next == LAST_IDX) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_LAUNCH;
          end
        end
        ST_FIN:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered handshake/status outputs, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_enc_valid <= (w_state_nxt == ST_LAUNCH);
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
      r_done      <= (w_state_nxt == ST_FIN);
    end
  end

  // Seed latch, trial index and injector bit-select; flip_sel only moves on
  // accept, advance or abort so it is stable from LAUNCH through CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed <= '0;
      r_idx  <= BASELINE_IDX;
      r_flip <= NO_FLIP;
    end else if (w_accept) begin
      r_seed <= seed;
      r_idx  <= BASELINE_IDX;
      r_flip <= NO_FLIP;
    end else if (w_abort) begin
      r_flip <= NO_FLIP;
    end else if (w_adv) begin
      r_idx  <= w_p_next;
      r_flip <= (w_p_next == LAST_IDX) ? NO_FLIP : {{(32-CNT_W){1'b0}}, w_p_next};
    end else begin
      r_idx  <= r_idx;
      r_flip <= r_flip;
    end
  end

  // Capture the decoder result of the current trial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout   <= '0;
      r_corr   <= 1'b0;
      r_uncorr <= 1'b0;
    end else if (w_cap) begin
      r_dout   <= dec_dout;
      r_corr   <= dec_corr;
      r_uncorr <= dec_uncorr;
    end else begin
      r_dout   <= r_dout;
      r_corr   <= r_corr;
      r_uncorr <= r_uncorr;
    end
  end

  // Result counters: cleared on accept, timeouts count as failures too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= '0;
      r_fail <= '0;
      r_tmo  <= '0;
    end else if (w_accept) begin
      r_pass <= '0;
      r_fail <= '0;
      r_tmo  <= '0;
    end else begin
      r_pass <= w_pass_evt ? sat_inc(r_pass) : r_pass;
      r_fail <= (w_fail_evt || w_tmo_evt) ? sat_inc(r_fail) : r_fail;
      r_tmo  <= w_tmo_evt ? sat_inc(r_tmo) : r_tmo;
    end
  end

`ifdef FAULT_LOG_EN
  logic [CNT_W-1:0]  r_ff_pos;
  logic [DATA_W-1:0] r_ff_data;

  // Remember the first failing trial; a zero fail count marks "none yet".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_pos  <= CNT_MAX;
      r_ff_data <= '0;
    end else if (w_accept) begin
      r_ff_pos  <= CNT_MAX;
      r_ff_data <= '0;
    end else if ((w_fail_evt || w_tmo_evt) && (r_fail == '0)) begin
      r_ff_pos  <= r_idx;
      r_ff_data <= w_fail_evt ? r_dout : '0;
    end else begin
      r_ff_pos  <= r_ff_pos;
      r_ff_data <= r_ff_data;
    end
  end

  assign first_fail_pos  = r_ff_pos;
  assign first_fail_data = r_ff_data;
`endif

  assign enc_din   = r_seed;
  assign enc_valid = r_enc_valid;
  assign flip_sel  = r_flip;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass_cnt  = r_pass;
  assign fail_cnt  = r_fail;
  assign tmo_cnt   = r_tmo;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: a behavioural decoder plus a per-trial
// reference model of the scoring rules, a vector table of campaign scenarios,
// randomized campaigns and hand-written abort / reset sequences.
module tb_fault_campaign_ctrl;

  localparam int DATA_W   = 32;
  localparam int NUM_BITS = 40;
  localparam int TIMEOUT  = 16;
  localparam int TRIALS   = NUM_BITS + 1;
  localparam int LIMIT    = TRIALS * (TIMEOUT + 6) + 20;
  localparam logic [31:0] NOF = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] seed = '0;
  logic [DATA_W-1:0] enc_din;
  logic              enc_valid;
  logic [31:0]       flip_sel;
  logic [DATA_W-1:0] dec_dout = '0;
  logic              dec_corr = 1'b0;
  logic              dec_uncorr = 1'b0;
  logic              dec_valid = 1'b0;
  logic              busy;
  logic              done;
  logic [7:0]        pass_cnt;
  logic [7:0]        fail_cnt;
  logic [7:0]        tmo_cnt;
`ifdef FAULT_LOG_EN
  logic [7:0]        first_fail_pos;
  logic [DATA_W-1:0] first_fail_data;
`endif

  fault_campaign_ctrl #(.DATA_W(DATA_W), .NUM_BITS(NUM_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .enc_din(enc_din), .enc_valid(enc_valid), .flip_sel(flip_sel),
    .dec_dout(dec_dout), .dec_corr(dec_corr), .dec_uncorr(dec_uncorr),
    .dec_valid(dec_valid), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
`ifdef FAULT_LOG_EN
    , .first_fail_pos(first_fail_pos), .first_fail_data(first_fail_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // decoder configuration
  int cfg_lat = 2;
  int cfg_mode = 0;  // 0 ideal, 1 uncorr at cfg_pos, 2 corr on baseline, 3 bad data at cfg_pos
  int cfg_pos = 0;
  bit rand_mode = 1'b0;
  logic [DATA_W-1:0] tb_seed = '0;

  // decoder pending reply
  int cd = 0;
  logic [DATA_W-1:0] pend_dout = '0;
  logic pend_corr = 1'b0;
  logic pend_unc = 1'b0;

  // monitor and reference model
  int cyc = 0, ev_cnt = 0, flip_err = 0, din_err = 0, done_cnt = 0, gap = 0, last_ev = 0;
  int ref_pass = 0, ref_fail = 0, ref_tmo = 0;
  bit ref_have = 1'b0;
  logic [7:0] ref_ffp = 8'hFF;
  logic [DATA_W-1:0] ref_ffd = '0;

  typedef struct {
    int lat; int mode; int pos;
    int e_pass; int e_fail; int e_tmo; int e_gap;
    logic [7:0] e_ffp;
  } vec_t;
  vec_t tv [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decide the decoder reply for the trial just launched and score it by the
  // pass rules: clean decode on baseline, corrected decode on a flipped bit,
  // payload equal to the seed, timeout when no reply within TIMEOUT cycles.
  task automatic plan_trial();
    logic is_base, tmo_now, ok;
    logic [7:0] pos;
    int lat, k;
    logic [DATA_W-1:0] dd;
    logic dc, du;
    is_base = (flip_sel == NOF);
    pos = flip_sel[7:0];
    lat = cfg_lat; dd = tb_seed; dc = !is_base; du = 1'b0;
    if (rand_mode) begin
      k = int'($urandom_range(0, 5));
      lat = int'($urandom_range(1, TIMEOUT + 2));
      case (k)
        1: lat = 0;
        2: begin du = 1'b1; dc = 1'b0; end
        3: dd = tb_seed ^ (32'h1 << $urandom_range(0, 31));
        4: dc = !dc;
        default: ;
      endcase
    end else begin
      case (cfg_mode)
        1: if (!is_base && int'(pos) == cfg_pos) begin du = 1'b1; dc = 1'b0; end
        2: if (is_base) dc = 1'b1;
        3: if (!is_base && int'(pos) == cfg_pos) dd = tb_seed ^ 32'h1;
        default: ;
      endcase
    end
    tmo_now = (lat == 0) || (lat > TIMEOUT);
    ok = !tmo_now && (dd == tb_seed) && !du && (is_base ? !dc : dc);
    if (tmo_now) begin ref_fail++; ref_tmo++; end
    else if (ok) ref_pass++;
    else ref_fail++;
    if (!ok && !ref_have) begin
      ref_have = 1'b1;
      ref_ffp = is_base ? 8'hFE : pos;
      ref_ffd = tmo_now ? '0 : dd;
    end
    pend_dout = dd; pend_corr = dc; pend_unc = du; cd = lat;
  endtask

  // Decoder model and output monitor, both on the falling edge.
  always @(negedge clk) begin
    logic [31:0] exp_flip;
    cyc++;
    dec_valid = 1'b0;
    dec_dout = $urandom;
    dec_corr = 1'($urandom_range(0, 1));
    dec_uncorr = 1'($urandom_range(0, 1));
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        dec_valid = 1'b1; dec_dout = pend_dout; dec_corr = pend_corr; dec_uncorr = pend_unc;
      end
    end
    if (enc_valid) begin
      exp_flip = (ev_cnt == 0) ? NOF : 32'(ev_cnt - 1);
      if (flip_sel !== exp_flip) flip_err++;
      if (enc_din !== tb_seed) din_err++;
      ev_cnt++;
      gap = cyc - last_ev;
      last_ev = cyc;
      plan_trial();
    end
    if (done) done_cnt++;
  end

  task automatic start_campaign(input logic [DATA_W-1:0] s, input bit with_abort);
    #1;
    tb_seed = s; ev_cnt = 0; flip_err = 0; din_err = 0; done_cnt = 0;
    ref_pass = 0; ref_fail = 0; ref_tmo = 0; ref_have = 1'b0; ref_ffp = 8'hFF; ref_ffd = '0;
    @(negedge clk); seed = s; start = 1'b1; abort = with_abort;
    @(negedge clk); start = 1'b0; abort = 1'b0; seed = $urandom;
  endtask

  task automatic wait_done(input bit extra_start);
    bit seen, sent;
    seen = 1'b0; sent = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (extra_start && !sent && ev_cnt == 5) begin start = 1'b1; seed = ~tb_seed; sent = 1'b1; end
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    @(negedge clk); #1;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic check_campaign(input string tag);
    chk({tag, "_enc_pulses"}, 64'(ev_cnt), 64'(TRIALS));
    chk({tag, "_flip_seq_err"}, 64'(flip_err), 64'd0);
    chk({tag, "_enc_din_err"}, 64'(din_err), 64'd0);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_pass_plus_fail"}, 64'(int'(pass_cnt) + int'(fail_cnt)), 64'(TRIALS));
  endtask

  initial begin
    bit seen;
    tv[0] = '{lat: 2,  mode: 0, pos: 0,  e_pass: 41, e_fail: 0,  e_tmo: 0,  e_gap: 5,  e_ffp: 8'hFF};
    tv[1] = '{lat: 0,  mode: 0, pos: 0,  e_pass: 0,  e_fail: 41, e_tmo: 41, e_gap: 18, e_ffp: 8'hFE};
    tv[2] = '{lat: 2,  mode: 1, pos: 7,  e_pass: 40, e_fail: 1,  e_tmo: 0,  e_gap: 5,  e_ffp: 8'd7};
    tv[3] = '{lat: 2,  mode: 2, pos: 0,  e_pass: 40, e_fail: 1,  e_tmo: 0,  e_gap: 5,  e_ffp: 8'hFE};
    tv[4] = '{lat: 16, mode: 0, pos: 0,  e_pass: 41, e_fail: 0,  e_tmo: 0,  e_gap: 19, e_ffp: 8'hFF};
    tv[5] = '{lat: 17, mode: 0, pos: 0,  e_pass: 0,  e_fail: 41, e_tmo: 41, e_gap: 18, e_ffp: 8'hFE};
    tv[6] = '{lat: 1,  mode: 3, pos: 39, e_pass: 40, e_fail: 1,  e_tmo: 0,  e_gap: 4,  e_ffp: 8'd39};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_enc_din", 64'(enc_din), 64'd0);
    chk("rst_enc_valid", 64'(enc_valid), 64'd0);
    chk("rst_flip_sel", 64'(flip_sel), 64'(NOF));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_counters", {40'd0, pass_cnt, fail_cnt, tmo_cnt}, 64'd0);
`ifdef FAULT_LOG_EN
    chk("rst_ffp", 64'(first_fail_pos), 64'hFF);
    chk("rst_ffd", 64'(first_fail_data), 64'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // table-driven scenarios
    for (int i = 0; i < 7; i++) begin
      cfg_lat = tv[i].lat; cfg_mode = tv[i].mode; cfg_pos = tv[i].pos; rand_mode = 1'b0;
      start_campaign(32'hA5A5_5A5A ^ DATA_W'(i), 1'b0);
      #1;
      chk($sformatf("t%0d_busy_start", i), 64'(busy), 64'd1);
      wait_done(1'b0);
      check_campaign($sformatf("t%0d", i));
      chk($sformatf("t%0d_pass", i), 64'(pass_cnt), 64'(tv[i].e_pass));
      chk($sformatf("t%0d_fail", i), 64'(fail_cnt), 64'(tv[i].e_fail));
      chk($sformatf("t%0d_tmo", i), 64'(tmo_cnt), 64'(tv[i].e_tmo));
      chk($sformatf("t%0d_trial_gap", i), 64'(gap), 64'(tv[i].e_gap));
`ifdef FAULT_LOG_EN
      chk($sformatf("t%0d_ffp", i), 64'(first_fail_pos), 64'(tv[i].e_ffp));
      chk($sformatf("t%0d_ffd", i), 64'(first_fail_data), 64'(ref_ffd));
`endif
    end

    // randomized campaigns against the reference model
    rand_mode = 1'b1;
    for (int r = 0; r < 4; r++) begin
      start_campaign($urandom, 1'b0);
      wait_done(1'b0);
      check_campaign($sformatf("r%0d", r));
      chk($sformatf("r%0d_pass", r), 64'(pass_cnt), 64'(ref_pass));
      chk($sformatf("r%0d_fail", r), 64'(fail_cnt), 64'(ref_fail));
      chk($sformatf("r%0d_tmo", r), 64'(tmo_cnt), 64'(ref_tmo));
`ifdef FAULT_LOG_EN
      chk($sformatf("r%0d_ffp", r), 64'(first_fail_pos), 64'(ref_ffp));
      chk($sformatf("r%0d_ffd", r), 64'(first_fail_data), 64'(ref_ffd));
`endif
    end
    rand_mode = 1'b0;

    // abort during WAIT of p=12
    cfg_lat = 2; cfg_mode = 0;
    start_campaign(32'hA5A5_5A5A, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk); #1;
      if (enc_valid && flip_sel == 32'd12) begin seen = 1'b1; break; end
    end
    chk("abort_reach_p12", 64'(seen), 64'd1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_flip_sel", 64'(flip_sel), 64'(NOF));
    chk("abort_enc_valid", 64'(enc_valid), 64'd0);
    chk("abort_pass_hold", 64'(pass_cnt), 64'd13);
    chk("abort_fail_hold", 64'(fail_cnt), 64'd0);
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_pass_later", 64'(pass_cnt), 64'd13);
    // start and abort together in IDLE: start is taken
    start_campaign(32'h5A5A_A5A5, 1'b1);
    #1;
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_pass_clr", 64'(pass_cnt), 64'd0);
    wait_done(1'b0);
    check_campaign("restart");
    chk("restart_pass", 64'(pass_cnt), 64'd41);

    // asynchronous reset during LAUNCH, then a campaign with a start while busy
    start_campaign(32'h1234_5678, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk); #1;
      if (enc_valid && ev_cnt == 3) begin seen = 1'b1; break; end
    end
    chk("rst_reach_launch", 64'(seen), 64'd1);
    chk("rst_pre_pass", 64'(pass_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_enc_valid", 64'(enc_valid), 64'd0);
    chk("arst_counters", {40'd0, pass_cnt, fail_cnt, tmo_cnt}, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_flip_sel", 64'(flip_sel), 64'(NOF));
    chk("arst_enc_din", 64'(enc_din), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    start_campaign(32'h0F0F_3C3C, 1'b0);
    wait_done(1'b1);
    check_campaign("busy_start");
    chk("busy_start_pass", 64'(pass_cnt), 64'd41);
    chk("busy_start_fail", 64'(fail_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
